// File: rtl/sap_ram_16x8.sv
// 16x8 program/data RAM for the SAP bus computer: registered bus reads, run-mode bus writes,
// and a synchronised, debounced manual-write button for loading programs by hand.
module sap_ram_16x8 #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned ADDR_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              n_prog_write,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              n_ram_in,
    input  logic              n_ram_out,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              prog_ack
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
    localparam logic [1:0] ST_WRITE        = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_bus_out;
    logic              r_bus_oe;
    logic              r_sync1;
    logic              r_sync_n;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;

    logic [1:0]        w_state_d;
    logic [CNT_W-1:0]  w_cnt_d;
    logic              w_prog_we;
    logic              w_run_we;

    assign w_prog_we = (r_state == ST_WRITE);
    assign w_run_we  = ~prog_mode & ~n_ram_in;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        if (!prog_mode) begin
            // Leaving program mode abandons any press in progress.
            w_state_d = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_sync_n) begin
                        w_state_d = ST_DEBOUNCE;
                        w_cnt_d   = '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_sync_n) begin
                        w_state_d = ST_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_d = ST_WRITE;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                ST_WRITE:        w_state_d = ST_WAIT_RELEASE;
                ST_WAIT_RELEASE: if (r_sync_n) w_state_d = ST_IDLE;
                default:         w_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_bus_out <= '0;
            r_bus_oe  <= 1'b0;
            r_sync1   <= 1'b1;
            r_sync_n  <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= n_prog_write;
            r_sync_n  <= r_sync1;
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            // Read uses the pre-write contents, so a same-edge write is seen one edge later.
            r_bus_out <= r_mem[addr];
            r_bus_oe  <= ~n_ram_out & ~prog_mode;
            if (w_prog_we) begin
                r_mem[addr] <= data_in;
            end else if (w_run_we) begin
                r_mem[addr] <= bus_in;
            end
        end
    end

    assign bus_out  = r_bus_out;
    assign bus_oe   = r_bus_oe;
    assign prog_ack = (r_state == ST_WRITE);

endmodule

// File: tb/tb_sap_ram_16x8.sv
// Self-checking bench for sap_ram_16x8: vector table, random run-mode traffic against an array
// model, and hand-timed program-button sequences.
module tb_sap_ram_16x8;

    logic       clk = 1'b0;
    logic       rst;
    logic       prog_mode;
    logic [3:0] addr;
    logic [7:0] data_in;
    logic       n_prog_write;
    logic [7:0] bus_in;
    logic       n_ram_in;
    logic       n_ram_out;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       prog_ack;

    int errors = 0;
    int checks = 0;
    logic [7:0] mdl [16];

    always #5 clk = ~clk;

    sap_ram_16x8 dut (
        .clk          (clk),
        .rst          (rst),
        .prog_mode    (prog_mode),
        .addr         (addr),
        .data_in      (data_in),
        .n_prog_write (n_prog_write),
        .bus_in       (bus_in),
        .n_ram_in     (n_ram_in),
        .n_ram_out    (n_ram_out),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .prog_ack     (prog_ack)
    );

    typedef struct {
        logic       wr;
        logic [3:0] a;
        logic [7:0] d;
        logic       rd;
        logic [7:0] exp_out;
        logic       exp_oe;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    endtask

    task automatic read_chk(input logic [3:0] a, input string name);
        prog_mode = 1'b0;
        n_ram_in  = 1'b1;
        n_ram_out = 1'b0;
        addr      = a;
        tick();
        check(name, {24'd0, bus_out}, {24'd0, mdl[a]});
        check({name, "_oe"}, {31'd0, bus_oe}, 32'd1);
        n_ram_out = 1'b1;
    endtask

    // Full press: ack must appear only after the 7th edge counted from the press.
    task automatic prog_write(input logic [3:0] a, input logic [7:0] d, input string name);
        prog_mode    = 1'b1;
        addr         = a;
        data_in      = d;
        n_prog_write = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check(name, {31'd0, prog_ack}, {31'd0, (i == 7)});
        end
        mdl[a]       = d;
        n_prog_write = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        rst = 1'b1; prog_mode = 1'b0; addr = '0; data_in = '0; n_prog_write = 1'b1;
        bus_in = '0; n_ram_in = 1'b1; n_ram_out = 1'b1;
        tick();
        tick();
        check("reset_bus_out", {24'd0, bus_out}, 32'd0);
        check("reset_bus_oe", {31'd0, bus_oe}, 32'd0);
        check("reset_ack", {31'd0, prog_ack}, 32'd0);
        rst = 1'b0;
        clear_model();

        // {wr, addr, data, rd, expected bus_out, expected bus_oe}
        vecs[0] = '{1'b1, 4'h3, 8'hA5, 1'b1, 8'h00, 1'b1};
        vecs[1] = '{1'b0, 4'h3, 8'h00, 1'b1, 8'hA5, 1'b1};
        vecs[2] = '{1'b1, 4'h0, 8'h5A, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 4'h0, 8'h00, 1'b1, 8'h5A, 1'b1};
        vecs[4] = '{1'b1, 4'hF, 8'h81, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{1'b0, 4'hF, 8'h00, 1'b1, 8'h81, 1'b1};
        vecs[6] = '{1'b1, 4'h3, 8'hC3, 1'b1, 8'hA5, 1'b1};
        vecs[7] = '{1'b0, 4'h3, 8'h00, 1'b1, 8'hC3, 1'b1};
        vecs[8] = '{1'b0, 4'h0, 8'h00, 1'b0, 8'h5A, 1'b0};
        for (int v = 0; v < 9; v++) begin
            prog_mode = 1'b0;
            addr      = vecs[v].a;
            bus_in    = vecs[v].d;
            n_ram_in  = ~vecs[v].wr;
            n_ram_out = ~vecs[v].rd;
            tick();
            check($sformatf("vec%0d_out", v), {24'd0, bus_out}, {24'd0, vecs[v].exp_out});
            check($sformatf("vec%0d_oe", v), {31'd0, bus_oe}, {31'd0, vecs[v].exp_oe});
            if (vecs[v].wr) mdl[vecs[v].a] = vecs[v].d;
        end
        n_ram_in  = 1'b1;
        n_ram_out = 1'b1;

        // Random run-mode traffic with prog_mode toggling; button untouched.
        for (int c = 0; c < 300; c++) begin
            logic [7:0] exp_out;
            logic       exp_oe;
            prog_mode = ($urandom_range(0, 3) == 0);
            n_ram_in  = $urandom_range(0, 1) != 0;
            n_ram_out = $urandom_range(0, 1) != 0;
            addr      = 4'($urandom_range(0, 15));
            bus_in    = 8'($urandom_range(0, 255));
            data_in   = 8'($urandom_range(0, 255));
            exp_out   = mdl[addr];
            exp_oe    = !n_ram_out && !prog_mode;
            tick();
            check("rand_out", {24'd0, bus_out}, {24'd0, exp_out});
            check("rand_oe", {31'd0, bus_oe}, {31'd0, exp_oe});
            check("rand_ack", {31'd0, prog_ack}, 32'd0);
            if (!prog_mode && !n_ram_in) mdl[addr] = bus_in;
        end
        n_ram_in  = 1'b1;
        n_ram_out = 1'b1;
        prog_mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_chk(4'(i), $sformatf("rand_final_%0d", i));
        end

        // Fill with 0xFF, then reset with a write strobe pending at the same edge.
        n_ram_in = 1'b0;
        bus_in   = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            tick();
        end
        rst       = 1'b1;
        addr      = 4'h5;
        bus_in    = 8'h11;
        n_ram_out = 1'b0;
        tick();
        check("rst_clr_bus_out", {24'd0, bus_out}, 32'd0);
        check("rst_clr_bus_oe", {31'd0, bus_oe}, 32'd0);
        rst      = 1'b0;
        n_ram_in = 1'b1;
        clear_model();
        for (int i = 0; i < 16; i++) begin
            read_chk(4'(i), $sformatf("rst_clr_%0d", i));
        end

        // Program write held 20 cycles; bus_out tracks mem[0xE] two edges after WRITE is entered.
        prog_mode    = 1'b1;
        addr         = 4'hE;
        data_in      = 8'h3C;
        n_ram_out    = 1'b0;
        n_prog_write = 1'b0;
        begin
            int acks = 0;
            for (int i = 1; i <= 20; i++) begin
                tick();
                check($sformatf("prog_ack_%0d", i), {31'd0, prog_ack}, {31'd0, (i == 7)});
                check("prog_oe", {31'd0, bus_oe}, 32'd0);
                check($sformatf("prog_out_%0d", i), {24'd0, bus_out},
                      (i >= 9) ? 32'h3C : {24'd0, mdl[4'hE]});
                if (prog_ack) acks++;
            end
            check("prog_ack_count", acks, 32'd1);
        end
        mdl[4'hE]    = 8'h3C;
        n_prog_write = 1'b1;
        n_ram_out    = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        read_chk(4'hE, "prog_readback");

        // Three-cycle glitch must be rejected.
        prog_mode    = 1'b1;
        addr         = 4'h2;
        data_in      = 8'h44;
        n_prog_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("glitch_ack", {31'd0, prog_ack}, 32'd0);
        end
        n_prog_write = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("glitch_ack", {31'd0, prog_ack}, 32'd0);
        end
        read_chk(4'h2, "glitch_mem");

        // Abort while debouncing by leaving program mode, with the button still held.
        prog_mode    = 1'b1;
        addr         = 4'h4;
        data_in      = 8'h55;
        n_prog_write = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        prog_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_ack", {31'd0, prog_ack}, 32'd0);
        end
        n_prog_write = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        read_chk(4'h4, "abort_mem");

        // Run-mode strobe is ignored in program mode.
        prog_mode = 1'b1;
        addr      = 4'h4;
        bus_in    = 8'h77;
        n_ram_in  = 1'b0;
        tick();
        tick();
        n_ram_in = 1'b1;
        read_chk(4'h4, "ignored_strobe_mem");
        prog_write(4'h4, 8'h66, "after_abort_ack");
        read_chk(4'h4, "after_abort_mem");

        // Reset while in WRITE: the pending commit is dropped.
        prog_mode    = 1'b1;
        addr         = 4'h9;
        data_in      = 8'h99;
        n_prog_write = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("midrst_in_write", {31'd0, prog_ack}, 32'd1);
        rst          = 1'b1;
        n_prog_write = 1'b1;
        tick();
        check("midrst_ack", {31'd0, prog_ack}, 32'd0);
        check("midrst_oe", {31'd0, bus_oe}, 32'd0);
        check("midrst_out", {24'd0, bus_out}, 32'd0);
        rst = 1'b0;
        clear_model();
        read_chk(4'h9, "midrst_mem9");
        read_chk(4'hE, "midrst_memE");
        prog_write(4'h9, 8'h5B, "midrst_idle_ack");
        read_chk(4'h9, "midrst_rewrite");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
